bram_delay_prog: RTL and testbench

BRAM_DELAY_PROG -- requirements
Module: bram_delay_prog

---
 rtl/bram_delay_prog.sv | 158 +++++++++++++++
 tb/tb_bram_delay_prog.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_delay_prog.sv
// Programmable delay line built on one simple dual-port RAM.
// Delay is changed at run time; output is masked while the line refills.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset
//   ce         clock enable; all state holds while low
//   delay_in   requested delay in clocks (ADDR_BITS+1 bits)
//   delay_load one-cycle strobe capturing delay_in
//   din        input data word
//   din_vld    input data valid
//   dout       delayed data word (undefined while busy)
//   dout_vld   delayed valid, forced low while busy
//   busy       high while the line is flushing after a delay change

module bram_delay_prog #(
   parameter  int WIDTH     = 32,
   parameter  int MAX_DELAY = 1024,
   parameter  int LATENCY   = 2,
   localparam int ADDR_BITS = $clog2(MAX_DELAY)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic [ADDR_BITS:0]   delay_in,
   input  logic                 delay_load,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_vld,
   output logic [WIDTH-1:0]     dout,
   output logic                 dout_vld,
   output logic                 busy
);

   typedef enum logic {
      FLUSH = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic [ADDR_BITS:0]   MIN_D = LATENCY + 1;
   localparam logic [ADDR_BITS:0]   MAX_D = MAX_DELAY;
   localparam logic [ADDR_BITS:0]   ONE_D = 1;
   localparam logic [ADDR_BITS-1:0] ONE_A = 1;
   localparam logic [ADDR_BITS-1:0] LAT_A = LATENCY;

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [ADDR_BITS:0]   cur_delay;
   logic [ADDR_BITS:0]   delay_clamped;
   logic [ADDR_BITS:0]   flush_ctr;
   logic [ADDR_BITS:0]   flush_ctr_nxt;
   logic                 load;

   logic [WIDTH:0]       mem [MAX_DELAY];
   logic [WIDTH:0]       rd_q;

   assign load = ce & delay_load;

   // Requested delay limited to what the RAM pipeline can realise.
   always_comb begin
      delay_clamped = delay_in;
      if (delay_in < MIN_D)
         delay_clamped = MIN_D;
      else if (delay_in > MAX_D)
         delay_clamped = MAX_D;
   end

   // The read pipeline adds LATENCY clocks, so the read trails the
   // write by (cur_delay - LATENCY) words.  Only the low ADDR_BITS
   // of cur_delay matter modulo MAX_DELAY.  For every legal delay the
   // read and write addresses of the same edge differ.
   assign rd_addr = wr_ptr - cur_delay[ADDR_BITS-1:0] + LAT_A;

   // Datapath RAM: not reset, stale contents are hidden by FLUSH.
   always_ff @(posedge clk) begin
      if (ce && !rst)
         mem[wr_ptr] <= {din_vld, din};
   end

   generate
      if (LATENCY == 1) begin : g_lat1
         always_ff @(posedge clk) begin
            if (ce)
               rd_q <= mem[rd_addr];
         end
      end else begin : g_lat2
         logic [ADDR_BITS-1:0] rd_addr_q;

         always_ff @(posedge clk) begin
            if (ce) begin
               rd_addr_q <= rd_addr;
               rd_q      <= mem[rd_addr_q];
            end
         end
      end
   endgenerate

   // Pointer and delay register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         cur_delay <= MAX_D;
      end else if (ce) begin
         wr_ptr <= wr_ptr + ONE_A;
         if (delay_load)
            cur_delay <= delay_clamped;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FLUSH;
         flush_ctr <= '0;
      end else if (ce) begin
         state     <= state_nxt;
         flush_ctr <= flush_ctr_nxt;
      end
   end

   // FSM next state: a load always (re)starts a full flush with the
   // new delay; otherwise FLUSH lasts exactly cur_delay cycles.
   always_comb begin
      state_nxt     = state;
      flush_ctr_nxt = flush_ctr;
      unique case (state)
         FLUSH: begin
            if (load) begin
               flush_ctr_nxt = '0;
            end else if (flush_ctr == cur_delay - ONE_D) begin
               state_nxt     = RUN;
               flush_ctr_nxt = '0;
            end else begin
               flush_ctr_nxt = flush_ctr + ONE_D;
            end
         end
         RUN: begin
            if (load) begin
               state_nxt     = FLUSH;
               flush_ctr_nxt = '0;
            end
         end
         default: begin
            state_nxt     = FLUSH;
            flush_ctr_nxt = '0;
         end
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy     = (state == FLUSH);
      dout_vld = rd_q[WIDTH] & (state == RUN);
      dout     = rd_q[WIDTH-1:0];
   end

endmodule

// File: tb/tb_bram_delay_prog.sv
// Randomised bench for bram_delay_prog with a queue-style history model.
// Also pins several hand-computed delays, flush lengths and patterns.

module tb_bram_delay_prog;

   localparam int W    = 32;
   localparam int MAXD = 1024;
   localparam int LAT  = 2;
   localparam int AB   = $clog2(MAXD);
   localparam int HN   = 4096;

   logic          clk;
   logic          rst;
   logic          ce;
   logic [AB:0]   delay_in;
   logic          delay_load;
   logic [W-1:0]  din;
   logic          din_vld;
   logic [W-1:0]  dout;
   logic          dout_vld;
   logic          busy;

   int total = 0;
   int bad   = 0;

   bram_delay_prog #(
      .WIDTH(W),
      .MAX_DELAY(MAXD),
      .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ce(ce),
      .delay_in(delay_in),
      .delay_load(delay_load),
      .din(din),
      .din_vld(din_vld),
      .dout(dout),
      .dout_vld(dout_vld),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: every enabled clock appends {vld,data} to a
   // history; in steady state the output is the entry md clocks back.
   // rem = clocks of flushing still to go.
   logic [W:0] hist [HN];
   int         wn    = 0;
   int         md    = MAXD;
   int         rem   = MAXD;
   bit         armed = 0;

   function automatic int clampd(input int v);
      int r;
      r = v;
      if (r < LAT + 1) r = LAT + 1;
      if (r > MAXD)    r = MAXD;
      return r;
   endfunction

   always @(posedge clk) begin
      logic         s_rst, s_ce, s_ld, s_v;
      logic [AB:0]  s_di;
      logic [W-1:0] s_d;
      logic [W:0]   e;
      s_rst = rst;
      s_ce  = ce;
      s_ld  = delay_load;
      s_di  = delay_in;
      s_d   = din;
      s_v   = din_vld;
      #1;
      if (s_rst) begin
         md    = MAXD;
         rem   = MAXD;
         armed = 1;
      end else if (armed && s_ce) begin
         hist[wn % HN] = {s_v, s_d};
         wn++;
         if (s_ld) begin
            md  = clampd(int'(s_di));
            rem = md;
         end else if (rem > 0) begin
            rem--;
         end
      end
      if (armed) begin
         total++;
         if (rem > 0) begin
            if (busy !== 1'b1 || dout_vld !== 1'b0) begin
               bad++;
               $display("FAIL model_flush t=%0t busy=%b vld=%b want busy=1 vld=0",
                        $time, busy, dout_vld);
            end
         end else begin
            e = hist[(wn - md) & (HN - 1)];
            if (busy !== 1'b0 || dout_vld !== e[W] ||
                (e[W] && dout !== e[W-1:0])) begin
               bad++;
               $display("FAIL model_run t=%0t busy=%b vld=%b dout=%h want busy=0 vld=%b dout=%h",
                        $time, busy, dout_vld, dout, e[W], e[W-1:0]);
            end
         end
      end
   end

   // Stimulus and literal checks.
   logic [W-1:0] last_din;
   bit           auto_cnt;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      if (ce) begin
         last_din = din;
         if (auto_cnt) din = din + 1;
      end
   endtask

   function automatic int lag();
      return int'(last_din - dout) + 1;
   endfunction

   task automatic count_busy(output int c);
      c = 0;
      while (busy && c < 5000) begin
         c++;
         tick();
      end
   endtask

   task automatic load_count(input int d, output int c);
      delay_in   = (AB + 1)'(d);
      delay_load = 1'b1;
      tick();
      delay_load = 1'b0;
      count_busy(c);
   endtask

   initial begin
      int c;
      logic pat [16];
      logic obs [16];

      rst        = 1'b1;
      ce         = 1'b1;
      delay_load = 1'b0;
      delay_in   = '0;
      din        = '0;
      din_vld    = 1'b1;
      last_din   = '0;
      auto_cnt   = 1;
      repeat (3) tick();
      chk("reset_busy", int'(busy), 1);
      chk("reset_vld", int'(dout_vld), 0);
      rst = 1'b0;

      // Delay 16 with counter data.
      load_count(16, c);
      chk("flush_16", c, 16);
      repeat (20) tick();
      chk("lag_16", lag(), 16);
      chk("vld_16", int'(dout_vld), 1);

      // Clamp low and high.
      load_count(1, c);
      chk("flush_clamp_lo", c, 3);
      repeat (5) tick();
      chk("lag_clamp_lo", lag(), 3);
      load_count(MAXD + 5, c);
      chk("flush_clamp_hi", c, MAXD);
      repeat (5) tick();
      chk("lag_clamp_hi", lag(), MAXD);

      // Valid pattern 1,0,0,1 at delay 10.
      load_count(10, c);
      chk("flush_10", c, 10);
      for (int i = 0; i < 16; i++) pat[i] = 1'b1;
      pat[1] = 1'b0;
      pat[2] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din_vld = pat[i];
         tick();
         obs[i] = dout_vld;
      end
      din_vld = 1'b1;
      chk("pat_0", int'(obs[9]), 1);
      chk("pat_1", int'(obs[10]), 0);
      chk("pat_2", int'(obs[11]), 0);
      chk("pat_3", int'(obs[12]), 1);

      // Stall of 7 clocks at delay 20.
      load_count(20, c);
      chk("flush_20", c, 20);
      repeat (5) tick();
      ce = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("stall_lag", lag(), 20);
      end
      ce = 1'b1;
      repeat (3) tick();
      chk("resume_lag", lag(), 20);

      // 8 -> 32, then 8 -> 32 interrupted by 12 on flush cycle 5.
      load_count(8, c);
      chk("flush_8", c, 8);
      repeat (4) tick();
      load_count(32, c);
      chk("flush_32", c, 32);
      repeat (4) tick();
      chk("lag_32", lag(), 32);
      load_count(8, c);
      delay_in   = (AB + 1)'(32);
      delay_load = 1'b1;
      tick();
      delay_load = 1'b0;
      repeat (4) tick();
      chk("busy_mid_flush", int'(busy), 1);
      load_count(12, c);
      chk("flush_restart_12", c, 12);
      repeat (3) tick();
      chk("lag_12", lag(), 12);

      // Random traffic, stalls and loads.
      auto_cnt = 0;
      for (int i = 0; i < 1500; i++) begin
         din        = $urandom;
         din_vld    = 1'($urandom % 2);
         ce         = ($urandom % 8) != 0;
         delay_load = ($urandom % 100) == 0;
         delay_in   = (AB + 1)'($urandom_range(0, MAXD + 8));
         tick();
      end
      ce         = 1'b1;
      delay_load = 1'b0;

      // Long run at MAX delay across wraps, reset in the middle.
      load_count(MAXD, c);
      chk("flush_max", c, MAXD);
      for (int i = 0; i < 1600; i++) begin
         din     = $urandom;
         din_vld = 1'($urandom % 4 != 0);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy(c);
      chk("flush_after_reset", c, MAXD);
      for (int i = 0; i < 1700; i++) begin
         din     = $urandom;
         din_vld = 1'($urandom % 4 != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
